// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the rotation- and vectoring-mode CORDIC blocks.
// Angles use a binary full scale of 2^width = one turn; the top two bits give the quadrant.
// Supported angle widths: 4..32 bits.
package cordic_pkg;

  // Arctan table file shared with the rotation CORDIC; arctan32() below holds the same values.
  localparam string ARCTAN_FILE = "arctan.mem";

  // round(2^32 / K), K = prod sqrt(1 + 2^-2i) ~= 1.6467602581.
  localparam logic [31:0] CORDIC_INV_GAIN = 32'h9B74_EDA8;

  typedef enum logic [1:0] {
    StIdle,
    StRotate,
    StGain,
    StDone
  } cordic_state_e;

  // +90 degrees at the given angle width.
  function automatic logic [63:0] quarter_turn(input int unsigned width);
    return 64'd1 << (width - 2);
  endfunction

  // 180 degrees at the given angle width.
  function automatic logic [63:0] half_turn(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

  // round(atan(2^-i) * 2^32 / 2pi).
  function automatic logic [31:0] arctan32(input int unsigned i);
    logic [31:0] v;
    case (i)
      0:       v = 32'h2000_0000;
      1:       v = 32'h12E4_051E;
      2:       v = 32'h09FB_385B;
      3:       v = 32'h0511_11D4;
      4:       v = 32'h028B_0D43;
      5:       v = 32'h0145_D7E1;
      6:       v = 32'h00A2_F61E;
      7:       v = 32'h0051_7C55;
      8:       v = 32'h0028_BE53;
      9:       v = 32'h0014_5F2F;
      10:      v = 32'h000A_2F98;
      11:      v = 32'h0005_17CC;
      12:      v = 32'h0002_8BE6;
      13:      v = 32'h0001_45F3;
      14:      v = 32'h0000_A2FA;
      15:      v = 32'h0000_517D;
      16:      v = 32'h0000_28BE;
      17:      v = 32'h0000_145F;
      18:      v = 32'h0000_0A30;
      19:      v = 32'h0000_0518;
      20:      v = 32'h0000_028C;
      21:      v = 32'h0000_0146;
      22:      v = 32'h0000_00A3;
      23:      v = 32'h0000_0051;
      24:      v = 32'h0000_0029;
      25:      v = 32'h0000_0014;
      26:      v = 32'h0000_000A;
      27:      v = 32'h0000_0005;
      28:      v = 32'h0000_0003;
      29:      v = 32'h0000_0001;
      30:      v = 32'h0000_0001;
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  // Rescale a 32-bit-full-scale constant to a narrower angle width, rounding to nearest.
  function automatic logic [31:0] scale_to_width(input logic [31:0] v, input int unsigned width);
    logic [32:0] e;
    int unsigned s;
    s = 32 - width;
    if (s == 0) return v;
    e = {1'b0, v} + (33'd1 << (s - 1));
    return 32'(e >> s);
  endfunction

  function automatic logic [31:0] arctan_entry(input int unsigned i, input int unsigned width);
    return scale_to_width(arctan32(i), width);
  endfunction

  // round(2^width / K).
  function automatic logic [31:0] inv_gain(input int unsigned width);
    return scale_to_width(CORDIC_INV_GAIN, width);
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring-mode micro-rotation: drives y toward zero and accumulates the
// rotated angle into z. All outputs are functions of the pre-update inputs.
module cordic_vec_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic signed [WIDTH+1:0] x_i,
  input  logic signed [WIDTH+1:0] y_i,
  input  logic        [WIDTH-1:0] z_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  input  logic        [WIDTH-1:0] atan_i,
  output logic signed [WIDTH+1:0] x_o,
  output logic signed [WIDTH+1:0] y_o,
  output logic        [WIDTH-1:0] z_o
);

  logic signed [WIDTH+1:0] x_sh;
  logic signed [WIDTH+1:0] y_sh;

  assign x_sh = x_i >>> shift_i;
  assign y_sh = y_i >>> shift_i;

  // Rotate clockwise when y is non-negative, counter-clockwise otherwise.
  always_comb begin
    if (!y_i[WIDTH+1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_i;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_i;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: returns magnitude and atan2 angle of (x_0, y_0), one
// micro-rotation per clock, valid/ready on both sides, one job in flight at a time.
// Optional build macro CORDIC_GAIN_COMP_EN: adds a GAIN state that scales the magnitude by 1/K.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ITERATIONS = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_0,
  input  logic signed [WIDTH-1:0] y_0,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [WIDTH:0]   mag,
  output logic        [WIDTH-1:0] angle
);

  // Two guard bits absorb the CORDIC gain on a diagonal input and negation of the minimum value.
  localparam int unsigned XW = WIDTH + 2;
  localparam int unsigned CW = $clog2(ITERATIONS);

  localparam logic [CW-1:0]    LAST_CNT = CW'(ITERATIONS - 1);
  localparam logic [WIDTH-1:0] QUARTER  = WIDTH'(quarter_turn(WIDTH));
  localparam logic [WIDTH-1:0] HALF     = WIDTH'(half_turn(WIDTH));

  cordic_state_e state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0]     z_q, z_d;
  logic [WIDTH:0]       mag_q, mag_d;
  logic [WIDTH-1:0]     angle_q, angle_d;
  logic                 out_valid_q, out_valid_d;

  logic signed [XW-1:0] x_ext, y_ext;
  logic signed [XW-1:0] pre_x, pre_y;
  logic [WIDTH-1:0]     pre_z;
  logic signed [XW-1:0] x_nxt, y_nxt;
  logic [WIDTH-1:0]     z_nxt;
  logic [WIDTH-1:0]     atan_i;

  assign x_ext = {{2{x_0[WIDTH-1]}}, x_0};
  assign y_ext = {{2{y_0[WIDTH-1]}}, y_0};

  // Fold left-half-plane inputs into the right half-plane so the iterations converge.
  always_comb begin
    pre_x = x_ext;
    pre_y = y_ext;
    pre_z = '0;
    if (x_0[WIDTH-1]) begin
      if (!y_0[WIDTH-1]) begin
        pre_x = y_ext;
        pre_y = -x_ext;
        pre_z = QUARTER;
      end else begin
        pre_x = -y_ext;
        pre_y = x_ext;
        pre_z = QUARTER + HALF;
      end
    end
  end

  assign atan_i = WIDTH'(arctan_entry(32'(cnt_q), WIDTH));

  cordic_vec_stage #(
    .WIDTH   (WIDTH),
    .SHIFT_W (CW)
  ) u_stage (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (cnt_q),
    .atan_i  (atan_i),
    .x_o     (x_nxt),
    .y_o     (y_nxt),
    .z_o     (z_nxt)
  );

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [WIDTH-1:0] INV_GAIN = WIDTH'(inv_gain(WIDTH));
  // x is non-negative once pre-rotated, so an unsigned multiply is exact.
  logic [XW+WIDTH-1:0] gain_prod;
  assign gain_prod = (XW + WIDTH)'($unsigned(x_q)) * (XW + WIDTH)'(INV_GAIN);
`endif

  // Next-state logic: accept, iterate, publish, then wait for the consumer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    mag_d       = mag_q;
    angle_d     = angle_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = pre_x;
          y_d     = pre_y;
          z_d     = pre_z;
          cnt_d   = '0;
          state_d = StRotate;
        end
      end
      StRotate: begin
        // The counter runs one past the last shift so the final step settles before publishing.
        if (cnt_q == LAST_CNT) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d     = StGain;
`else
          mag_d       = x_q[WIDTH:0];
          angle_d     = z_q;
          out_valid_d = 1'b1;
          state_d     = StDone;
`endif
        end else begin
          x_d   = x_nxt;
          y_d   = y_nxt;
          z_d   = z_nxt;
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGain: begin
`ifdef CORDIC_GAIN_COMP_EN
        mag_d       = gain_prod[WIDTH +: WIDTH+1];
        angle_d     = z_q;
        out_valid_d = 1'b1;
        state_d     = StDone;
`else
        state_d     = StIdle;
`endif
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      mag_q       <= '0;
      angle_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      mag_q       <= mag_d;
      angle_q     <= angle_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign mag       = mag_q;
  assign angle     = angle_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring with hand-computed magnitudes and angles.
// Define CORDIC_GAIN_COMP_EN for both DUT and bench to check the gain-compensated build.
module tb_cordic_vectoring;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned ITERATIONS = 31;
`ifdef CORDIC_GAIN_COMP_EN
  localparam bit          GAIN_EN = 1'b1;
  localparam int unsigned LATENCY = ITERATIONS + 1;
`else
  localparam bit          GAIN_EN = 1'b0;
  localparam int unsigned LATENCY = ITERATIONS;
`endif
  // 2^32 / 2pi: converts a y-residual over magnitude (radians) into angle LSBs.
  localparam longint LSB_PER_RAD = 64'd683565276;
  // Floor truncation adds up to a few LSB of x/y error per micro-rotation.
  localparam longint QUANT = 3 * (ITERATIONS - 1);

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] x_0;
  logic signed [WIDTH-1:0] y_0;
  logic                    out_valid;
  logic                    out_ready;
  logic        [WIDTH:0]   mag;
  logic        [WIDTH-1:0] angle;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct packed {
    longint      x;
    longint      y;
    logic [31:0] ang;
    longint      kmag;  // K * |v|
    longint      tmag;  // |v|
  } vec_t;

  vec_t  vecs [6];
  string names[6];

  always #5 clk = ~clk;

  cordic_vectoring #(
    .WIDTH      (WIDTH),
    .ITERATIONS (ITERATIONS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_0       (x_0),
    .y_0       (y_0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag       (mag),
    .angle     (angle)
  );

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    longint diff;
    n_checks++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic start_job(input string tag, input longint x, input longint y);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_in_ready"}, longint'(in_ready), 1, 0);
    x_0      = WIDTH'(x);
    y_0      = WIDTH'(y);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, longint'(lat), longint'(LATENCY), 0);
  endtask

  task automatic check_result(input string tag, input vec_t v);
    longint mexp;
    longint mtol;
    longint atol;
    int     aerr;
    mexp = GAIN_EN ? v.tmag : v.kmag;
    mtol = mexp / 100000 + QUANT;
    atol = 8 + (QUANT * LSB_PER_RAD) / v.kmag;
    aerr = int'(angle - v.ang);  // modulo-2^32 angle difference
    check({tag, "_mag"}, longint'(mag), mexp, mtol);
    check({tag, "_angle_err"}, longint'(aerr), 0, atol);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_clr"}, longint'(out_valid), 0, 0);
    check({tag, "_idle_in_ready"}, longint'(in_ready), 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{x: 64'sd1048576,     y: 64'sd0,           ang: 32'h0000_0000,
                kmag: 64'sd1726753,    tmag: 64'sd1048576};
    vecs[1] = '{x: 64'sd1048576,     y: 64'sd1048576,     ang: 32'h2000_0000,
                kmag: 64'sd2441998,    tmag: 64'sd1482910};
    vecs[2] = '{x: 64'sd0,           y: 64'sd1048576,     ang: 32'h4000_0000,
                kmag: 64'sd1726753,    tmag: 64'sd1048576};
    vecs[3] = '{x: -64'sd1048576,    y: 64'sd0,           ang: 32'h8000_0000,
                kmag: 64'sd1726753,    tmag: 64'sd1048576};
    vecs[4] = '{x: 64'sd1048576,     y: -64'sd1048576,    ang: 32'hE000_0000,
                kmag: 64'sd2441998,    tmag: 64'sd1482910};
    vecs[5] = '{x: -64'sd2147483648, y: -64'sd2147483648, ang: 32'hA000_0000,
                kmag: 64'sd5001211727, tmag: 64'sd3037000500};
    names = '{"pos_x", "diag", "pos_y", "neg_x", "q4", "min_min"};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_0       = '0;
    y_0       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", longint'(out_valid), 0, 0);
    check("reset_in_ready", longint'(in_ready), 1, 0);
    check("reset_mag", longint'(mag), 0, 0);
    check("reset_angle", longint'(angle), 0, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      start_job(names[i], vecs[i].x, vecs[i].y);
      wait_result(names[i]);
      check_result(names[i], vecs[i]);
      release_result(names[i]);
    end

    // Zero vector: angle is arbitrary but must be defined; magnitude stays tiny.
    start_job("zero", 0, 0);
    wait_result("zero");
    check("zero_mag", longint'(mag), 0, 2 * (ITERATIONS - 1));
    check("zero_angle_known", longint'($isunknown(angle)), 0, 0);
    release_result("zero");

    // Back-pressure: result held, new requests ignored.
    start_job("hold", vecs[1].x, vecs[1].y);
    wait_result("hold");
    for (int k = 0; k < 10; k++) begin
      x_0      = WIDTH'(-64'sd12345 * (k + 1));
      y_0      = WIDTH'(64'sd777 * (k + 3));
      in_valid = (k % 2 == 0);
      @(posedge clk); #1;
      check("hold_out_valid", longint'(out_valid), 1, 0);
      check("hold_in_ready", longint'(in_ready), 0, 0);
      check_result("hold", vecs[1]);
    end
    in_valid = 1'b0;
    release_result("hold");
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (out_valid || !in_ready) seen++;
      end
      check("hold_no_ghost_job", longint'(seen), 0, 0);
    end

    // Reset mid-rotation: pending result is dropped.
    start_job("rst", vecs[0].x, vecs[0].y);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_out_valid", longint'(out_valid), 0, 0);
    check("rst_in_ready", longint'(in_ready), 1, 0);
    check("rst_mag", longint'(mag), 0, 0);
    check("rst_angle", longint'(angle), 0, 0);
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("rst_no_stale_result", longint'(seen), 0, 0);
    end
    start_job("after_rst", vecs[2].x, vecs[2].y);
    wait_result("after_rst");
    check_result("after_rst", vecs[2]);
    release_result("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
